// File: rtl/data_mem_responder.sv
// data_mem_responder: zero-latency data memory with byte-lane stores, a memory-mapped timer and sticky error capture
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TIMER_ADDR  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  input  logic [2:0]  mem_size,
  output logic [31:0] data_rdata,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  input  logic        err_clr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic {IDLE, CAPTURED} err_st_e;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] timer_q, timer_d;
  err_st_e     err_st_q;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] err_addr_q;
  logic [1:0]  size;
  logic        timer_hit, in_range, illegal, mis_ld, mis_st, oor, st_err, mem_we, timer_we, sgn;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wd, word, shifted;
  logic [7:0]  b;
  logic [15:0] h;
  // Address decode, access classification and lane steering for both loads and stores
  always_comb begin
    size      = mem_size[1:0];
    sgn       = ~mem_size[2];
    widx      = data_addr[AW+1:2];
    timer_hit = data_addr[31:2] == TIMER_ADDR[31:2];
    in_range  = data_addr[31:AW+2] == '0;
    oor       = !in_range && !timer_hit;
    illegal   = size == 2'b11 || mem_size[2:1] == 2'b11;
    mis_ld    = (size == 2'b01 && data_addr[0]) || (size == 2'b10 && data_addr[1:0] != 2'b00);
    mis_st    = mis_ld || (timer_hit && size != 2'b10);
    st_err    = data_we && (illegal || mis_st || oor);
    err_code_d = illegal ? 2'b11 : mis_st ? 2'b01 : 2'b10;
    mem_we    = data_we && !st_err && !timer_hit;
    timer_we  = data_we && !st_err && timer_hit;
    timer_d   = timer_we ? data_wdata : timer_q + 32'd1;
    be = size == 2'b00 ? 4'b0001 << data_addr[1:0] : size == 2'b01 ? (data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = size == 2'b00 ? {4{data_wdata[7:0]}} : size == 2'b01 ? {2{data_wdata[15:0]}} : data_wdata;
    word    = timer_hit ? timer_q : mem_q[widx];
    shifted = word >> {data_addr[1:0], 3'b000};
    b       = shifted[7:0];
    h       = data_addr[1] ? word[31:16] : word[15:0];
    data_rdata = (illegal || mis_ld || oor) ? 32'h0 :
                 size == 2'b00 ? {{24{sgn & b[7]}}, b} :
                 size == 2'b01 ? {{16{sgn & h[15]}}, h} : word;
  end
  // Storage is deliberately unreset so contents survive a mid-run reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
  end
  // Free-running timer, overwritten by a legal word store to its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= 32'h0;
    else timer_q <= timer_d;
  end
  // Sticky error capture: first error wins until cleared, a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_st_q   <= IDLE;
      err_code_q <= 2'b00;
      err_addr_q <= 32'h0;
    end else if (st_err && (err_st_q == IDLE || err_clr)) begin
      err_st_q   <= CAPTURED;
      err_code_q <= err_code_d;
      err_addr_q <= data_addr;
    end else if (err_clr) begin
      err_st_q   <= IDLE;
      err_code_q <= 2'b00;
      err_addr_q <= 32'h0;
    end
  end
  assign err_valid = err_st_q == CAPTURED;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven load/store vectors plus hand-written error, timer and reset sequences
module tb_data_mem_responder;
  localparam logic [31:0] TA = 32'hFFFF_0000;
  logic        clk = 0, rst_n = 0, data_we = 0, err_clr = 0;
  logic [31:0] data_addr = 0, data_wdata = 0, data_rdata, err_addr;
  logic [2:0]  mem_size = 3'b010;
  logic        err_valid;
  logic [1:0]  err_code;
  int passed = 0, total = 0;
  logic [31:0] sb [$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  sz;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t v [$];

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_we(data_we), .mem_size(mem_size), .data_rdata(data_rdata),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passed++;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] w, input logic we, input logic [2:0] sz,
                       input logic clr, input logic chk, input logic [31:0] exp, input string n);
    logic [31:0] e;
    @(posedge clk);
    #1;
    data_addr = a; data_wdata = w; data_we = we; mem_size = sz; err_clr = clr;
    if (chk) sb.push_back(exp);
    @(negedge clk);
    if (chk) begin
      e = sb.pop_front();
      check(n, data_rdata, e);
    end
  endtask

  task automatic idle();
    apply(32'h0, 32'h0, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  task automatic check_err(input string n, input logic ev, input logic [1:0] code, input logic [31:0] addr);
    check({n, ".valid"}, {31'h0, err_valid}, {31'h0, ev});
    check({n, ".code"}, {30'h0, err_code}, {30'h0, code});
    check({n, ".addr"}, err_addr, addr);
  endtask

  initial begin
    v.push_back(vec_t'{32'h10, 32'hDEADBEEF, 1'b1, 3'b010, 1'b0, 32'h0});
    v.push_back(vec_t'{32'h13, 32'h0, 1'b0, 3'b000, 1'b1, 32'hFFFFFFDE});
    v.push_back(vec_t'{32'h13, 32'h0, 1'b0, 3'b100, 1'b1, 32'h000000DE});
    v.push_back(vec_t'{32'h10, 32'h0, 1'b0, 3'b001, 1'b1, 32'hFFFFBEEF});
    v.push_back(vec_t'{32'h12, 32'h0, 1'b0, 3'b101, 1'b1, 32'h0000DEAD});
    v.push_back(vec_t'{32'h10, 32'h0, 1'b0, 3'b010, 1'b1, 32'hDEADBEEF});
    v.push_back(vec_t'{32'h10, 32'h55667788, 1'b1, 3'b010, 1'b1, 32'hDEADBEEF});
    v.push_back(vec_t'{32'h10, 32'h0, 1'b0, 3'b010, 1'b1, 32'h55667788});
    v.push_back(vec_t'{32'h20, 32'h11223344, 1'b1, 3'b010, 1'b0, 32'h0});
    v.push_back(vec_t'{32'h21, 32'h000000AA, 1'b1, 3'b000, 1'b0, 32'h0});
    v.push_back(vec_t'{32'h20, 32'h0, 1'b0, 3'b010, 1'b1, 32'h1122AA44});
    v.push_back(vec_t'{32'h11, 32'h0, 1'b0, 3'b001, 1'b1, 32'h0});
    v.push_back(vec_t'{32'h22, 32'h0, 1'b0, 3'b010, 1'b1, 32'h0});
    v.push_back(vec_t'{32'h4, 32'h0, 1'b0, 3'b011, 1'b1, 32'h0});
    v.push_back(vec_t'{32'h10000, 32'h0, 1'b0, 3'b010, 1'b1, 32'h0});
    v.push_back(vec_t'{32'h22, 32'h0, 1'b0, 3'b000, 1'b1, 32'h00000022});
    v.push_back(vec_t'{32'h22, 32'h12348001, 1'b1, 3'b001, 1'b0, 32'h0});
    v.push_back(vec_t'{32'h20, 32'h0, 1'b0, 3'b010, 1'b1, 32'h8001AA44});
    v.push_back(vec_t'{32'h22, 32'h0, 1'b0, 3'b001, 1'b1, 32'hFFFF8001});
    v.push_back(vec_t'{32'h23, 32'h0, 1'b0, 3'b100, 1'b1, 32'h00000080});

    #12;
    data_addr = TA;
    #1;
    check_err("reset", 1'b0, 2'b00, 32'h0);
    check("reset.timer", data_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;

    foreach (v[i]) begin
      apply(v[i].addr, v[i].wd, v[i].we, v[i].sz, 1'b0, v[i].chk, v[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.err_valid", i), {31'h0, err_valid}, 32'h0);
    end

    apply(32'h30, 32'h0, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0, "sw30");
    apply(32'h31, 32'h0000FFFF, 1'b1, 3'b001, 1'b0, 1'b0, 32'h0, "sh31");
    apply(32'h30, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h0, "mis.word_unchanged");
    check_err("mis", 1'b1, 2'b01, 32'h31);
    apply(32'h10000, 32'h12345678, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0, "sw_oor");
    idle();
    check_err("sticky", 1'b1, 2'b01, 32'h31);
    apply(32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h0, "clr");
    idle();
    check_err("cleared", 1'b0, 2'b00, 32'h0);

    apply(32'h10001, 32'h0, 1'b1, 3'b111, 1'b0, 1'b0, 32'h0, "illegal_st");
    idle();
    check_err("prio_illegal", 1'b1, 2'b11, 32'h10001);
    apply(32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h0, "clr");
    apply(32'h10001, 32'h0, 1'b1, 3'b001, 1'b0, 1'b0, 32'h0, "mis_oor_st");
    idle();
    check_err("prio_mis", 1'b1, 2'b01, 32'h10001);
    apply(32'h4000_0000, 32'h0, 1'b1, 3'b010, 1'b1, 1'b0, 32'h0, "clr_collide");
    idle();
    check_err("collide", 1'b1, 2'b10, 32'h4000_0000);
    apply(32'h0, 32'h0, 1'b0, 3'b010, 1'b1, 1'b0, 32'h0, "clr");

    apply(TA, 32'hFFFFFFFE, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0, "sw_timer");
    apply(TA, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFE, "timer0");
    apply(TA, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, "timer1");
    apply(TA, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'h00000000, "timer_wrap");
    check("timer.no_err", {31'h0, err_valid}, 32'h0);
    apply(TA, 32'd100, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0, "sw_timer100");
    apply(TA, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'd100, "timer100");
    apply(TA, 32'h0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, "sb_timer");
    apply(TA, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'd102, "timer_sb_ignored");
    check_err("timer_sb", 1'b1, 2'b01, TA);
    apply(TA + 32'h2, 32'h0, 1'b0, 3'b101, 1'b0, 1'b1, 32'h0, "timer_lhu_hi");
    apply(TA, 32'h0, 1'b0, 3'b100, 1'b0, 1'b1, 32'h00000068, "timer_lbu");

    apply(32'h40, 32'hCAFEF00D, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0, "sw40");
    apply(32'h40, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'hCAFEF00D, "lw40");
    check("pre_reset.err_valid", {31'h0, err_valid}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    check_err("midreset", 1'b0, 2'b00, 32'h0);
    check("midreset.mem", data_rdata, 32'hCAFEF00D);
    data_addr = TA;
    #1;
    check("midreset.timer", data_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    apply(32'h40, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 32'hCAFEF00D, "postreset.mem");
    check_err("postreset", 1'b0, 2'b00, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
- REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage, power of two.
- REQ-002 SHALL have parameter TIMER_ADDR, default 32'hFFFF_0000: word-aligned address of the memory-mapped timer register.
- REQ-003 SHALL have ports, clock and reset first:
  - clk  input  1  single clock; all state updates on its rising edge.
  - rst_n  input  1  reset, asynchronous, active-low.
  - data_addr  input  32  byte address from the core's MEM stage.
  - data_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
  - data_we  input  1  store strobe for this cycle.
  - mem_size  input  3  access size and signedness, in funct3 encoding.
  - data_rdata  output  32  load data, extended per mem_size.
  - err_valid  output  1  sticky access-error flag.
  - err_code  output  2  error kind: 01 misaligned, 10 out-of-range, 11 illegal size.
  - err_addr  output  32  data_addr of the first captured error.
  - err_clr  input  1  synchronous clear of the error state.

Function
- REQ-004 mem_size encoding SHALL be: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011, 110 and 111 are illegal.
- REQ-005 Loads SHALL be combinational, zero-cycle latency: data_rdata reflects data_addr and mem_size in the same cycle, because the core samples it at the next edge. There is no read strobe; data_rdata is always driven.
- REQ-006 Load lane select SHALL work as follows:
  - Byte: byte data_addr[1:0] of the word.
  - Half: half data_addr[1] of the word.
  - Sign-extended for 000/001; zero-extended for 100/101.
- REQ-007 Loads SHALL return 32'h0 in each of these cases, and SHALL NOT set any error:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0);
  - illegal size;
  - out-of-range address.
- REQ-008 Address decode SHALL be:
  - word index = data_addr[31:2];
  - in range when index < DEPTH_WORDS;
  - timer hit when data_addr[31:2] == TIMER_ADDR[31:2];
  - everything else is out of range.
- REQ-009 Stores SHALL commit at the rising edge where data_we=1. Size is taken from mem_size[1:0] (00 byte, 01 half, 10 word), and only the addressed byte lanes are written. Storage contents are not reset.
- REQ-010 Read-during-write to the same address SHALL return the old data in that cycle and the new data from the next cycle.
- REQ-011 A store that is misaligned, out-of-range or illegal-size SHALL NOT modify storage or the timer, and SHALL raise an error.
- REQ-012 When several error conditions apply to one store, error priority SHALL be illegal size > misaligned > out-of-range.
- REQ-013 Timer behaviour:
  - timer_q is 32 bits and increments by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
  - A word store to the timer hit loads data_wdata instead of incrementing that cycle.
  - A byte or half store to the timer hit is treated as misaligned (err_code 01), and the timer keeps incrementing.
  - Loads at the timer hit return timer_q with lane selection per REQ-006.
- REQ-014 Error state machine SHALL have two states, IDLE (err_valid=0) and CAPTURED (err_valid=1).
  - IDLE -> CAPTURED on an erroring store; err_code and err_addr are latched at that edge.
  - In CAPTURED, further errors SHALL NOT overwrite err_code or err_addr.
  - err_clr=1 moves to IDLE.
  - err_clr and a new erroring store in the same cycle: capture wins, and the new error is latched.
- REQ-015 Error outputs SHALL be registered; they appear the cycle after the offending store edge.

Reset
- REQ-016 While rst_n=0, asynchronously:
  - timer_q=0, err_valid=0, err_code=2'b00, err_addr=32'h0;
  - data_rdata remains combinational from storage.
- REQ-017 Reset deasserted mid-operation SHALL leave storage intact. The timer restarts from 0 on the first edge after release.

Verification
- REQ-018 Store-word then load: SW 32'hDEADBEEF @0x10, then LB @0x13 -> 32'hFFFFFFDE; LBU @0x13 -> 32'h000000DE; LH @0x10 -> 32'hFFFFBEEF; LHU @0x12 -> 32'h0000DEAD.
- REQ-019 Partial store: SW 32'h11223344 @0x20, then SB 32'h000000AA @0x21 -> LW @0x20 = 32'h1122AA44.
- REQ-020 Misaligned store: SH @0x31 with word 0x30 preloaded with 32'h0 -> word 0x30 unchanged; next cycle err_valid=1, err_code=01, err_addr=32'h31. A later out-of-range SW @0x10000 leaves err_code=01.
- REQ-021 Clear/capture collision: err_clr=1 in the same cycle as SW @0x4000_0000 (DEPTH_WORDS=1024) -> err_valid=1, err_code=10, err_addr=32'h4000_0000.
- REQ-022 Timer: SW 32'hFFFFFFFE @TIMER_ADDR, then LW at the timer on the following three cycles -> 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000.
- REQ-023 Reset mid-run: SW 32'hCAFEF00D @0x40, set an error, pulse rst_n low -> err_valid=0, timer=0, and LW @0x40 still = 32'hCAFEF00D.
